// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch stage with hold/redirect
package instr_fetch_pkg;

  // Major opcodes (instr[6:0]) of the base integer ISA
  typedef enum logic [6:0] {
    OP_LOAD     = 7'h03,
    OP_MISC_MEM = 7'h0F,
    OP_IMM      = 7'h13,
    OP_AUIPC    = 7'h17,
    OP_STORE    = 7'h23,
    OP_REG      = 7'h33,
    OP_LUI      = 7'h37,
    OP_BRANCH   = 7'h63,
    OP_JALR     = 7'h67,
    OP_JAL      = 7'h6F,
    OP_SYSTEM   = 7'h73
  } opcode_e;

  // funct3 (instr[14:12]); every encoding is named so any slice is a member
  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'd0,
    F3_SLL     = 3'd1,
    F3_SLT     = 3'd2,
    F3_SLTU    = 3'd3,
    F3_XOR     = 3'd4,
    F3_SRL_SRA = 3'd5,
    F3_OR      = 3'd6,
    F3_AND     = 3'd7
  } funct3_e;

  // funct7 (instr[31:25]) values used by the base and M extensions
  typedef enum logic [6:0] {
    F7_BASE   = 7'h00,
    F7_MULDIV = 7'h01,
    F7_ALT    = 7'h20
  } funct7_e;

endpackage

module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output opcode_e     op,
  output funct3_e     funct3,
  output funct7_e     funct7,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic        misaligned
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state;
  state_e      next_state;
  logic [31:0] fetch_pc;
  logic [31:0] next_fetch_pc;
  logic        req_valid_c;
  logic        instr_valid_c;
  logic        capture;
  logic        accept;
  logic        target_misaligned;

  // State register; reset always parks the FSM in REQ, abandoning any transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decode; responses are only looked at in WAIT
  always_comb begin
    next_state    = state;
    req_valid_c   = 1'b0;
    instr_valid_c = 1'b0;
    capture       = 1'b0;
    accept        = 1'b0;
    case (state)
      S_REQ: begin
        req_valid_c = 1'b1;
        if (imem_req_ready) begin
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          capture    = 1'b1;
          next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        instr_valid_c = 1'b1;
        if (instr_ready) begin
          accept     = 1'b1;
          next_state = S_REQ;
        end
      end
      default: begin
        next_state = S_REQ;
      end
    endcase
  end

  // Outputs are forced low while reset is held so nothing is requested or presented
  assign imem_req_valid = req_valid_c & rst_n;
  assign instr_valid    = instr_valid_c & rst_n;
  assign imem_addr      = {fetch_pc[31:2], 2'b00};

  assign pc_plus4          = pc + 32'd4;
  assign target_misaligned = pc_target[1:0] != 2'b00;

  // Redirect targets are word-aligned by dropping the low bits
  assign next_fetch_pc = pc_src ? {pc_target[31:2], 2'b00} : pc_plus4;

  // Fetch address advances only when decode accepts the held instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (accept) begin
      fetch_pc <= next_fetch_pc;
    end
  end

  // Capture the returned word and the address it was fetched from
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP;
      pc    <= RESET_PC;
    end else if (capture) begin
      instr <= imem_rsp_data;
      pc    <= fetch_pc;
    end
  end

  // One-cycle flag for a redirect whose target had nonzero low bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned <= 1'b0;
    end else begin
      misaligned <= accept & pc_src & target_misaligned;
    end
  end

  // Decoded fields are direct slices of the held instruction
  assign op     = opcode_e'(instr[6:0]);
  assign funct3 = funct3_e'(instr[14:12]);
  assign funct7 = funct7_e'(instr[31:25]);

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  opcode_e     op;
  funct3_e     funct3;
  funct7_e     funct7;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        misaligned;

  int n_cmp;
  int n_fail;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .op             (op),
    .funct3         (funct3),
    .funct7         (funct7),
    .pc_src         (pc_src),
    .pc_target      (pc_target),
    .misaligned     (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(negedge clk);
  endtask

  // Drive one request/response handshake starting from REQ; response one cycle after accept
  task automatic do_fetch(input logic [31:0] data);
    n_cmp++;
    if (imem_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_start_req_valid: got %b want 1", imem_req_valid);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hBAD0_BAD0;
  endtask

  // Accept the held instruction with the given redirect inputs, then scramble them
  task automatic do_accept(input logic src, input logic [31:0] tgt);
    instr_ready = 1'b1;
    pc_src      = src;
    pc_target   = tgt;
    step();
    instr_ready = 1'b0;
    pc_src      = 1'b1;
    pc_target   = 32'h5555_5557;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    n_cmp++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    n_cmp++;
    if (instr !== 32'h0000_0013 || pc !== 32'h0 || misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: instr=%h pc=%h mis=%b want 00000013/0/0", instr, pc, misaligned);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_first_req: valid=%b addr=%h want 1/0", imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_first_fetch();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_outputs: req_valid=%b instr_valid=%b want 0/0", imem_req_valid, instr_valid);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0050_0093;
    step();
    imem_rsp_valid = 1'b0;
    n_cmp++;
    if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || pc !== 32'h0) begin
      n_fail++;
      $display("FAIL first_capture: valid=%b instr=%h pc=%h want 1/00500093/0", instr_valid, instr, pc);
    end
    n_cmp++;
    if (op !== 7'h13 || funct3 !== 3'h0 || pc_plus4 !== 32'h4) begin
      n_fail++;
      $display("FAIL first_decode: op=%h f3=%h pc4=%h want 13/0/4", op, funct3, pc_plus4);
    end
  endtask

  task automatic test_hold_stall();
    instr_ready = 1'b0;
    pc_src      = 1'b1;
    pc_target   = 32'h0000_0800;
    for (int i = 0; i < 5; i++) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hFFFF_FFFF;
      step();
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || pc !== 32'h0 || imem_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: v=%b instr=%h pc=%h req=%b", i, instr_valid, instr, pc, imem_req_valid);
      end
    end
    imem_rsp_valid = 1'b0;
    do_accept(1'b0, 32'h0000_0800);
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_accept_next: req=%b addr=%h iv=%b want 1/4/0", imem_req_valid, imem_addr, instr_valid);
    end
  endtask

  task automatic test_redirect();
    do_fetch(32'h4020_8033);
    n_cmp++;
    if (pc !== 32'h4 || op !== 7'h33 || funct3 !== 3'h0 || funct7 !== 7'h20) begin
      n_fail++;
      $display("FAIL sub_decode: pc=%h op=%h f3=%h f7=%h want 4/33/0/20", pc, op, funct3, funct7);
    end
    do_accept(1'b1, 32'h0000_0100);
    n_cmp++;
    if (imem_addr !== 32'h100 || misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_aligned: addr=%h mis=%b want 100/0", imem_addr, misaligned);
    end
    do_fetch(32'h0000_6F6F);
    do_accept(1'b1, 32'h0000_0102);
    n_cmp++;
    if (imem_addr !== 32'h100 || misaligned !== 1'b1) begin
      n_fail++;
      $display("FAIL redirect_misaligned: addr=%h mis=%b want 100/1", imem_addr, misaligned);
    end
    step();
    n_cmp++;
    if (misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL misaligned_pulse_width: got %b want 0", misaligned);
    end
  endtask

  task automatic test_req_backpressure();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_0000 + 32'(i);
      step();
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL req_held[%0d]: req=%b addr=%h iv=%b want 1/100/0", i, imem_req_valid, imem_addr, instr_valid);
      end
    end
    imem_rsp_valid = 1'b0;
    do_fetch(32'h0010_2283);
    n_cmp++;
    if (instr !== 32'h0010_2283 || pc !== 32'h100 || funct3 !== 3'h2 || op !== 7'h03) begin
      n_fail++;
      $display("FAIL after_backpressure: instr=%h pc=%h f3=%h op=%h want 00102283/100/2/03", instr, pc, funct3, op);
    end
    do_accept(1'b0, 32'h0);
  endtask

  task automatic test_reset_in_wait();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || instr !== 32'h0000_0013 || pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_in_wait: iv=%b req=%b instr=%h pc=%h", instr_valid, imem_req_valid, instr, pc);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || instr !== 32'h0000_0013) begin
      n_fail++;
      $display("FAIL late_rsp_ignored: iv=%b req=%b addr=%h instr=%h", instr_valid, imem_req_valid, imem_addr, instr);
    end
    imem_rsp_valid = 1'b0;
    do_fetch(32'h00A0_0113);
    n_cmp++;
    if (instr !== 32'h00A0_0113 || pc !== 32'h0 || instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_fetch: instr=%h pc=%h iv=%b want 00a00113/0/1", instr, pc, instr_valid);
    end
  endtask

  task automatic test_wrap();
    do_accept(1'b1, 32'hFFFF_FFFC);
    n_cmp++;
    if (imem_addr !== 32'hFFFF_FFFC || misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_redirect: addr=%h mis=%b want fffffffc/0", imem_addr, misaligned);
    end
    do_fetch(32'h0000_0073);
    n_cmp++;
    if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_pc_plus4: pc=%h pc4=%h want fffffffc/0", pc, pc_plus4);
    end
    do_accept(1'b0, 32'h0000_0200);
    n_cmp++;
    if (imem_addr !== 32'h0 || imem_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_next_addr: addr=%h req=%b want 0/1", imem_addr, imem_req_valid);
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    instr_ready    = 1'b0;
    pc_src         = 1'b0;
    pc_target      = 32'h0;
    test_reset();
    test_first_fetch();
    test_hold_stall();
    test_redirect();
    test_req_backpressure();
    test_reset_in_wait();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-005 The block SHALL have port imem_req_ready  input  1  memory accepts the request this cycle.
REQ-006 The block SHALL have port imem_addr  output  32  fetch byte address, bits [1:0] always 0.
REQ-007 The block SHALL have port imem_rsp_valid  input  1  instruction word returned this cycle.
REQ-008 The block SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-009 The block SHALL have port instr  output  32  held instruction for decode.
REQ-010 The block SHALL have port instr_valid  output  1  instr, pc and decoded fields are valid.
REQ-011 The block SHALL have port instr_ready  input  1  decode/execute consumes the instruction this cycle.
REQ-012 The block SHALL have port pc  output  32  address of the held instruction.
REQ-013 The block SHALL have port pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-014 The block SHALL have port op  output  opcode_e  instr[6:0].
REQ-015 The block SHALL have port funct3  output  funct3_e  instr[14:12].
REQ-016 The block SHALL have port funct7  output  funct7_e  instr[31:25].
REQ-017 The block SHALL have port pc_src  input  1  1 = redirect to pc_target on the current accept.
REQ-018 The block SHALL have port pc_target  input  32  branch/jump target byte address.
REQ-019 The block SHALL have port misaligned  output  1  one-cycle pulse: redirect target had nonzero bits [1:0].

Function
REQ-020 The block SHALL implement FSM states REQ, WAIT, HOLD.
REQ-021 REQ: imem_req_valid=1, imem_addr=fetch_pc; on imem_req_ready go to WAIT; else stay.
REQ-022 WAIT: imem_req_valid=0; on imem_rsp_valid capture imem_rsp_data into instr and fetch_pc into pc, go to HOLD.
REQ-023 HOLD: instr_valid=1; when instr_ready=0, stay, with instr, pc, op, funct3, funct7 stable.
REQ-024 HOLD with instr_ready=1 (accept): fetch_pc SHALL update to pc_target when pc_src=1, else to pc_plus4, and the FSM SHALL go to REQ.
REQ-025 pc_src and pc_target SHALL be sampled only on an accept; at all other times they are ignored.
REQ-026 On a redirect with pc_target[1:0]!=0, fetch_pc SHALL be {pc_target[31:2],2'b00} and misaligned SHALL pulse for one cycle.
REQ-027 pc_plus4 at 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-028 imem_rsp_valid outside WAIT SHALL be ignored; at most one request SHALL be outstanding.
REQ-029 Request-to-accept latency SHALL be the minimum: request issued in the cycle after accept, instr_valid in the cycle after imem_rsp_valid.
REQ-030 op, funct3 and funct7 SHALL be pure slices of the registered instr, with no added latency.

Reset
REQ-031 When rst_n=0, the block SHALL asynchronously set state=REQ, fetch_pc=RESET_PC, pc=RESET_PC, instr=32'h0000_0013 (NOP), and misaligned=0.
REQ-032 During reset, instr_valid=0 and imem_req_valid=0; the first request SHALL be issued in the first cycle after rst_n rises.
REQ-033 Reset in WAIT or HOLD SHALL abandon the transaction; a late imem_rsp_valid after reset SHALL be ignored, since state is REQ.

Verification
REQ-034 Scenario: reset release, imem_req_ready=1, response 32'h00500093 one cycle later -> imem_addr=0, then instr_valid=1, pc=0, op=7'h13, funct3=0.
REQ-035 Scenario: instr_ready held 0 for 5 cycles in HOLD -> instr/pc stable, no new imem_req_valid; accept -> next imem_addr=4.
REQ-036 Scenario: accept with pc_src=1, pc_target=32'h100 -> next imem_addr=32'h100, misaligned=0; pc_target=32'h102 -> imem_addr=32'h100, misaligned pulses once.
REQ-037 Scenario: imem_req_ready low 3 cycles -> imem_req_valid and imem_addr held steady; spurious imem_rsp_valid in REQ ignored.
REQ-038 Scenario: rst_n asserted in WAIT, response arrives during and after reset -> ignored, restart fetch at RESET_PC.
REQ-039 Scenario: pc=32'hFFFF_FFFC accepted with pc_src=0 -> pc_plus4=0, next imem_addr=0.
